// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: round-robin arbitration of two writeback ports onto the single
// register-file write port, plus a per-register busy scoreboard driving the issue stall.
module regfile_wb_scheduler #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [ADDR_WIDTH-1:0]        a_rd,
    input  logic [DATA_WIDTH-1:0]        a_data,
    input  logic                         b_valid,
    output logic                         b_ready,
    input  logic [ADDR_WIDTH-1:0]        b_rd,
    input  logic [DATA_WIDTH-1:0]        b_data,
    input  logic                         iss_valid,
    input  logic                         iss_has_rd,
    input  logic [ADDR_WIDTH-1:0]        iss_rs1,
    input  logic [ADDR_WIDTH-1:0]        iss_rs2,
    input  logic [ADDR_WIDTH-1:0]        iss_rd,
    output logic                         iss_stall,
    output logic                         rf_wen,
    output logic [ADDR_WIDTH-1:0]        rf_rd,
    output logic [DATA_WIDTH-1:0]        rf_data,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy
);

    localparam int NREG = 1 << ADDR_WIDTH;

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } ptr_e;

    ptr_e                  ptr_q, ptr_d;
    logic                  grant_a, grant_b, accept;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  set_en;

    // Handshake: a write transfers in the cycle valid & ready are both high; ready is the
    // combinational grant, and an ungranted requester keeps rd/data stable until granted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        ptr_d   = ptr_q;
        if (a_valid && b_valid) begin
            if (ptr_q == PTR_A) begin
                grant_a = 1'b1;
                ptr_d   = PTR_B;
            end else begin
                grant_b = 1'b1;
                ptr_d   = PTR_A;
            end
        end else begin
            grant_a = a_valid;
            grant_b = b_valid;
        end
    end

    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign accept   = grant_a | grant_b;
    assign sel_rd   = grant_a ? a_rd : b_rd;
    assign sel_data = grant_a ? a_data : b_data;

    // x0 writes are consumed but never assert the write enable.
    always_comb begin
        wen_d  = accept && (sel_rd != '0);
        rd_d   = rd_q;
        data_d = data_q;
        if (accept) begin
            rd_d   = sel_rd;
            data_d = sel_data;
        end
    end

    assign iss_stall = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] |
                                    (iss_has_rd & busy_q[iss_rd]));
    assign set_en    = iss_valid & iss_has_rd & ~iss_stall & (iss_rd != '0);

    // Clear on commit first so a same-cycle set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wen_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (set_en) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= PTR_A;
            wen_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            busy_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            wen_q  <= wen_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign rf_wen  = wen_q;
    assign rf_rd   = rd_q;
    assign rf_data = data_q;
    assign busy    = busy_q;

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Schedules all writes into the core register file and tracks which registers have writes pending.
- Arbitrates the single register-file write port between two writeback requesters: port A (ALU/exec) and port B (load/LSU). Arbitration is round-robin with valid/ready handshakes.
- Keeps a per-register busy scoreboard and raises an issue hazard for RAW and WAW conflicts.
- Sits between the execute/memory stages and the register file; drives the register file's rd, wen and dataD inputs.

Parameters:
ADDR_WIDTH, 5, register index width; register count = 1<<ADDR_WIDTH.
DATA_WIDTH, 64, register data width.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
a_valid  input  1  port A has a write.
a_ready  output  1  port A write accepted this cycle.
a_rd  input  ADDR_WIDTH  port A destination.
a_data  input  DATA_WIDTH  port A data.
b_valid  input  1  port B has a write.
b_ready  output  1  port B write accepted this cycle.
b_rd  input  ADDR_WIDTH  port B destination.
b_data  input  DATA_WIDTH  port B data.
iss_valid  input  1  decode is issuing an instruction.
iss_has_rd  input  1  the issued instruction writes rd.
iss_rs1  input  ADDR_WIDTH  issue source 1.
iss_rs2  input  ADDR_WIDTH  issue source 2.
iss_rd  input  ADDR_WIDTH  issue destination.
iss_stall  output  1  hazard; decode must hold.
rf_wen  output  1  register file write enable.
rf_rd  output  ADDR_WIDTH  register file write index.
rf_data  output  DATA_WIDTH  register file write data.
busy  output  1<<ADDR_WIDTH  scoreboard vector; bit i = write to xi pending.

Behaviour:
Reset (async assert, sync release):
- rf_wen=0, rf_rd=0, rf_data=0, busy=0, round-robin pointer=A.

Arbitration (combinational grant):
- Only A valid -> grant A. Only B valid -> grant B.
- Both valid -> grant the pointer side; the pointer then flips to the other side.
- Pointer changes only when both are valid in the same cycle.
- a_ready/b_ready = grant. At most one is high per cycle; both are low when neither is valid.
- Handshake completes on valid & ready. An ungranted requester must hold rd/data stable until granted.

Output stage (1-cycle registered latency):
- A write accepted in cycle N appears on rf_wen/rf_rd/rf_data in cycle N+1.
- A write with rd==0 is accepted but produces rf_wen=0; rf_rd/rf_data update anyway.
- No accept in cycle N -> rf_wen=0 in N+1; rf_rd/rf_data hold their previous values.

Scoreboard:
- Set: busy[iss_rd] is set on posedge when iss_valid & iss_has_rd & !iss_stall & iss_rd!=0.
- Clear: busy[rf_rd] is cleared on posedge when rf_wen=1 (the commit cycle).
- Same register set and cleared in the same cycle -> set wins.
- busy[0] is always 0.

Hazard:
- iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_has_rd & busy[iss_rd])).
- Computed from registered busy state only. A register committing this cycle still stalls; it releases next cycle.
- x0 never stalls.

Other rules:
- Write accepted for a register that is not busy (e.g. a speculative flush): written normally. Clearing an already-clear bit is a no-op.
- Reset mid-operation: an in-flight output write is dropped (rf_wen=0) and busy clears immediately.

Test Plan:
- Reset: rst_n=0 with a_valid=1 -> rf_wen=0, busy=0, a_ready still 1 combinationally. Release, a_rd=3, a_data=0x11 -> rf_wen=1, rf_rd=3, rf_data=0x11 one cycle later.
- Contention: a_valid=b_valid=1 held 4 cycles with a_rd=1, b_rd=2 -> grants A,B,A,B. rf_rd sequence 1,2,1,2, each lagging its grant by 1 cycle.
- x0 write: b_valid=1, b_rd=0, b_data=0xFF -> b_ready=1; next cycle rf_wen=0. busy unchanged.
- RAW stall: issue rd=5 (busy[5]=1), then issue rs1=5 -> iss_stall=1. a_rd=5 accepted at cycle N -> rf_wen at N+1. busy[5] clears at the N+1 posedge, so iss_stall=1 through N+1 and 0 in N+2.
- Set/clear collision: busy[7]=1 with x7 committing (rf_wen=1, rf_rd=7) while issuing iss_rd=7 → Expected: per the hazard rule iss_stall=1, so the set is suppressed and busy[7]=0 next cycle. To check set-wins, force the hazard off (iss_has_rd=1 with iss_rd=7 and busy[7]=0 on a flushed path, while a write to x7 commits) → Expected: busy[7]=1 next cycle.
- Async reset mid-write: assert rst_n=0 between the accept edge and the commit edge → Expected: rf_wen=0 immediately and busy=0 with no clock edge.
